// File: rtl/ram_arbiter.sv
// Purpose: round-robin arbiter sharing one single-port RAM between the core LSU (port 0) and the NoC engine (port 1), with RMW lock.
// Latency: grant is combinational in the request cycle; read/error responses are valid exactly one cycle after acceptance.
// Backpressure: reqN_ready is the grant; a port not granted (contention or foreign lock) must hold its beat until ready.
module ram_arbiter #(
  parameter int unsigned RAM_SIZE = 1024,
  parameter int unsigned LOCK_MAX = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req0_we,
  input  logic        req0_lock,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  output logic        resp0_valid,
  output logic [31:0] resp0_rdata,
  output logic        resp0_err,
  input  logic        req1_valid,
  input  logic        req1_we,
  input  logic        req1_lock,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        resp1_valid,
  output logic [31:0] resp1_rdata,
  output logic        resp1_err,
  output logic [31:0] ram_address,
  output logic [31:0] ram_wrdata,
  output logic        ram_we,
  input  logic [31:0] ram_rddata,
  output logic        lock_timeout
);

  localparam logic [0:0]  ST_UNLOCKED = 1'b0;
  localparam logic [0:0]  ST_LOCKED   = 1'b1;
  localparam int unsigned CNT_W       = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);
  localparam logic [31:0] RAM_LIMIT   = 32'(RAM_SIZE);

  logic [0:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic [31:0]      addr_q, wdata_q;
  logic             resp0_valid_q, resp0_valid_d, resp0_err_q, resp0_err_d;
  logic             resp1_valid_q, resp1_valid_d, resp1_err_q, resp1_err_d;

  logic        gnt0, gnt1, accept;
  logic        sel_we, sel_lock, in_range, timeout;
  logic [31:0] sel_addr, sel_wdata;

  // Grant: the lock owner has exclusive access; otherwise round-robin against the last winner.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (state_q == ST_LOCKED) begin
        if (owner_q) gnt1 = req1_valid;
        else         gnt0 = req0_valid;
      end else if (req0_valid && req1_valid) begin
        if (last_grant_q) gnt0 = 1'b1;
        else              gnt1 = 1'b1;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign accept     = gnt0 | gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign sel_addr  = gnt1 ? req1_addr  : req0_addr;
  assign sel_wdata = gnt1 ? req1_wdata : req0_wdata;
  assign sel_we    = gnt1 ? req1_we    : req0_we;
  assign sel_lock  = gnt1 ? req1_lock  : req0_lock;
  assign in_range  = sel_addr < RAM_LIMIT;

  // RAM side: address/data hold their last accepted values when idle so the RAM port stays quiet.
  assign ram_address = accept ? sel_addr  : addr_q;
  assign ram_wrdata  = accept ? sel_wdata : wdata_q;
  assign ram_we      = accept & sel_we & in_range;

  // Forced release fires only when the owner stays silent through the last allowed cycle.
  assign timeout      = (state_q == ST_LOCKED) && !accept && (cnt_q == CNT_LAST);
  assign lock_timeout = timeout;

  // Lock FSM next-state: acquire on a locking beat, release on an unlocking owner beat or on timeout.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_UNLOCKED: begin
        if (accept && sel_lock) begin
          state_d = ST_LOCKED;
          owner_d = gnt1;
          cnt_d   = '0;
        end
      end
      ST_LOCKED: begin
        if (accept) begin
          cnt_d = '0;
          if (!sel_lock) state_d = ST_UNLOCKED;
        end else if (timeout) begin
          state_d = ST_UNLOCKED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_UNLOCKED;
        cnt_d   = '0;
      end
    endcase
  end

  // Response and round-robin bookkeeping: reads and any out-of-range beat get a response next cycle.
  always_comb begin
    resp0_valid_d = gnt0 & (~req0_we | ~in_range);
    resp0_err_d   = gnt0 & ~in_range;
    resp1_valid_d = gnt1 & (~req1_we | ~in_range);
    resp1_err_d   = gnt1 & ~in_range;
    last_grant_d  = accept ? gnt1 : last_grant_q;
  end

  // State registers; reset drops in-flight responses and any held lock immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_UNLOCKED;
      owner_q       <= 1'b0;
      cnt_q         <= '0;
      last_grant_q  <= 1'b1;
      addr_q        <= '0;
      wdata_q       <= '0;
      resp0_valid_q <= 1'b0;
      resp0_err_q   <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp1_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
      last_grant_q  <= last_grant_d;
      addr_q        <= ram_address;
      wdata_q       <= ram_wrdata;
      resp0_valid_q <= resp0_valid_d;
      resp0_err_q   <= resp0_err_d;
      resp1_valid_q <= resp1_valid_d;
      resp1_err_q   <= resp1_err_d;
    end
  end

  // Read data passes straight from the RAM in the response cycle; zero on errors and when idle.
  assign resp0_valid = resp0_valid_q;
  assign resp0_err   = resp0_err_q;
  assign resp0_rdata = (resp0_valid_q && !resp0_err_q) ? ram_rddata : 32'h0;
  assign resp1_valid = resp1_valid_q;
  assign resp1_err   = resp1_err_q;
  assign resp1_rdata = (resp1_valid_q && !resp1_err_q) ? ram_rddata : 32'h0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM model, vector table of per-cycle grants, response scoreboard.
// Responses are predicted from a shadow memory when a beat is expected to be accepted.
// Lock timeout and reset corner cases are driven as short hand-written sequences.
module tb_ram_arbiter;

  typedef struct packed {
    logic        v;
    logic        we;
    logic        lk;
    logic [31:0] a;
    logic [31:0] d;
  } beat_t;

  typedef struct {
    beat_t p0;
    beat_t p1;
    logic  r0;
    logic  r1;
    logic  we;
    logic  to;
  } vec_t;

  typedef struct {
    int unsigned due;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_we, req0_lock, req0_ready;
  logic [31:0] req0_addr, req0_wdata;
  logic        resp0_valid, resp0_err;
  logic [31:0] resp0_rdata;
  logic        req1_valid, req1_we, req1_lock, req1_ready;
  logic [31:0] req1_addr, req1_wdata;
  logic        resp1_valid, resp1_err;
  logic [31:0] resp1_rdata;
  logic [31:0] ram_address, ram_wrdata, ram_rddata;
  logic        ram_we, lock_timeout;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] shadow [0:1023];
  logic [31:0] mem [0:1023];
  logic        mem_ready = 1'b0;
  vec_t        tbl[$];

  ram_arbiter #(.RAM_SIZE(1024), .LOCK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_lock(req0_lock),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata), .resp0_err(resp0_err),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_lock(req1_lock),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata), .resp1_err(resp1_err),
    .ram_address(ram_address), .ram_wrdata(ram_wrdata), .ram_we(ram_we),
    .ram_rddata(ram_rddata), .lock_timeout(lock_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM, 1-cycle read latency, read-before-write; RAM[i] = i*33 at start.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'(i * 33);
      mem_ready <= 1'b1;
    end else begin
      ram_rddata <= mem[ram_address[9:0]];
      if (ram_we) mem[ram_address[9:0]] <= ram_wrdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic beat_t RD(input logic [31:0] a, input logic lk);
    beat_t b;
    b = '{v: 1'b1, we: 1'b0, lk: lk, a: a, d: 32'h0};
    return b;
  endfunction

  function automatic beat_t WR(input logic [31:0] a, input logic [31:0] d, input logic lk);
    beat_t b;
    b = '{v: 1'b1, we: 1'b1, lk: lk, a: a, d: d};
    return b;
  endfunction

  function automatic beat_t IDLE();
    beat_t b;
    b = '0;
    return b;
  endfunction

  function automatic vec_t V(input beat_t b0, input beat_t b1, input logic r0, input logic r1, input logic we);
    vec_t v;
    v.p0 = b0; v.p1 = b1; v.r0 = r0; v.r1 = r1; v.we = we; v.to = 1'b0;
    return v;
  endfunction

  // Predict the effect of a beat the bench expects to be accepted.
  task automatic predict(input beat_t b, input bit port);
    exp_t e;
    logic inr;
    inr = b.a < 32'd1024;
    e.due   = cyc + 1;
    e.err   = !inr;
    e.rdata = inr ? shadow[b.a[9:0]] : 32'h0;
    if (!b.we || !inr) begin
      if (port) q1.push_back(e);
      else      q0.push_back(e);
    end
    if (b.we && inr) shadow[b.a[9:0]] = b.d;
  endtask

  task automatic drive(input beat_t b0, input beat_t b1);
    req0_valid = b0.v; req0_we = b0.we; req0_lock = b0.lk; req0_addr = b0.a; req0_wdata = b0.d;
    req1_valid = b1.v; req1_we = b1.we; req1_lock = b1.lk; req1_addr = b1.a; req1_wdata = b1.d;
  endtask

  task automatic apply(input vec_t v, input bit sb);
    @(posedge clk); #1;
    drive(v.p0, v.p1);
    if (sb && v.r0) predict(v.p0, 1'b0);
    if (sb && v.r1) predict(v.p1, 1'b1);
    @(negedge clk);
    check("req0_ready", req0_ready, v.r0);
    check("req1_ready", req1_ready, v.r1);
    check("ram_we", ram_we, v.we);
    check("lock_timeout", lock_timeout, v.to);
    if (v.r0) check("ram_address_p0", ram_address, v.p0.a);
    if (v.r1) check("ram_address_p1", ram_address, v.p1.a);
    if (v.we && v.r0) check("ram_wrdata_p0", ram_wrdata, v.p0.d);
    if (v.we && v.r1) check("ram_wrdata_p1", ram_wrdata, v.p1.d);
  endtask

  // Reset pulse one cycle after the preceding beat, with a write attempted while in reset.
  task automatic mid_reset();
    @(posedge clk); #1;
    drive(WR(32'd9, 32'hBAD0BAD0, 1'b0), IDLE());
    rst = 1'b1;
    #1;
    check("rst_drops_resp0", resp0_valid, 1'b0);
    check("rst_drops_resp1", resp1_valid, 1'b0);
    check("rst_no_ram_we", ram_we, 1'b0);
    @(posedge clk); #1;
    drive(IDLE(), IDLE());
    rst = 1'b0;
  endtask

  // Response monitor: resp valid must match the scoreboard every cycle; data/err checked on each due entry.
  always @(negedge clk) begin
    if (!rst && mem_ready) begin
      exp_t e;
      logic exp_v;
      exp_v = (q0.size() > 0) && (q0[0].due == cyc);
      check("resp0_valid", resp0_valid, exp_v);
      if (exp_v) begin
        e = q0.pop_front();
        check("resp0_rdata", resp0_rdata, e.rdata);
        check("resp0_err", resp0_err, e.err);
      end
      exp_v = (q1.size() > 0) && (q1[0].due == cyc);
      check("resp1_valid", resp1_valid, exp_v);
      if (exp_v) begin
        e = q1.pop_front();
        check("resp1_rdata", resp1_rdata, e.rdata);
        check("resp1_err", resp1_err, e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    for (int i = 0; i < 1024; i++) shadow[i] = 32'(i * 33);

    // Contention: both write every cycle, losers hold their beat; grants 0,1,0,1.
    tbl.push_back(V(WR(32'h10, 32'h10, 1'b0), WR(32'h20, 32'h20, 1'b0), 1'b1, 1'b0, 1'b1));
    tbl.push_back(V(WR(32'h11, 32'h11, 1'b0), WR(32'h20, 32'h20, 1'b0), 1'b0, 1'b1, 1'b1));
    tbl.push_back(V(WR(32'h11, 32'h11, 1'b0), WR(32'h21, 32'h21, 1'b0), 1'b1, 1'b0, 1'b1));
    tbl.push_back(V(WR(32'h12, 32'h12, 1'b0), WR(32'h21, 32'h21, 1'b0), 1'b0, 1'b1, 1'b1));
    // Single read of RAM[5]=0xA5, then back-to-back reads of written data.
    tbl.push_back(V(RD(32'd5, 1'b0), IDLE(), 1'b1, 1'b0, 1'b0));
    tbl.push_back(V(RD(32'h10, 1'b0), RD(32'h20, 1'b0), 1'b0, 1'b1, 1'b0));
    tbl.push_back(V(RD(32'h10, 1'b0), IDLE(), 1'b1, 1'b0, 1'b0));
    // Out of range write and read on port 1.
    tbl.push_back(V(IDLE(), WR(32'd1024, 32'hDEAD, 1'b0), 1'b0, 1'b1, 1'b0));
    tbl.push_back(V(IDLE(), RD(32'hFFFF_FFFF, 1'b0), 1'b0, 1'b1, 1'b0));
    // Atomic RMW by port 1 while port 0 keeps requesting.
    tbl.push_back(V(IDLE(), RD(32'd7, 1'b1), 1'b0, 1'b1, 1'b0));
    tbl.push_back(V(RD(32'd3, 1'b0), IDLE(), 1'b0, 1'b0, 1'b0));
    tbl.push_back(V(RD(32'd3, 1'b0), WR(32'd7, 32'hE8, 1'b0), 1'b0, 1'b1, 1'b1));
    tbl.push_back(V(RD(32'd3, 1'b0), IDLE(), 1'b1, 1'b0, 1'b0));
    // Port 0 lock held across a lock=1 beat, then released.
    tbl.push_back(V(RD(32'd8, 1'b1), IDLE(), 1'b1, 1'b0, 1'b0));
    tbl.push_back(V(WR(32'd8, 32'h55, 1'b1), RD(32'd8, 1'b0), 1'b1, 1'b0, 1'b1));
    tbl.push_back(V(RD(32'd8, 1'b0), RD(32'd8, 1'b0), 1'b1, 1'b0, 1'b0));
    tbl.push_back(V(RD(32'd9, 1'b0), RD(32'd8, 1'b0), 1'b0, 1'b1, 1'b0));
    tbl.push_back(V(RD(32'd9, 1'b0), IDLE(), 1'b1, 1'b0, 1'b0));
    tbl.push_back(V(IDLE(), IDLE(), 1'b0, 1'b0, 1'b0));

    rst = 1'b1;
    drive(IDLE(), IDLE());
    repeat (2) @(posedge clk);
    #1;
    check("reset_resp0_valid", resp0_valid, 1'b0);
    check("reset_resp1_valid", resp1_valid, 1'b0);
    check("reset_resp0_rdata", resp0_rdata, 32'h0);
    check("reset_resp1_err", resp1_err, 1'b0);
    check("reset_lock_timeout", lock_timeout, 1'b0);
    check("reset_ram_we", ram_we, 1'b0);
    rst = 1'b0;

    foreach (tbl[i]) apply(tbl[i], 1'b1);

    // Lock timeout with LOCK_MAX=4: pulse in the 4th cycle after the lock beat.
    apply(V(RD(32'd2, 1'b1), IDLE(), 1'b1, 1'b0, 1'b0), 1'b1);
    for (int k = 1; k <= 4; k++) begin
      v = V(IDLE(), RD(32'd4, 1'b0), 1'b0, 1'b0, 1'b0);
      v.to = (k == 4);
      apply(v, 1'b1);
    end
    apply(V(IDLE(), RD(32'd4, 1'b0), 1'b0, 1'b1, 1'b0), 1'b1);

    // Reset mid-read: last_grant must return to 1, so port 0 wins contention; no write during reset.
    apply(V(RD(32'd6, 1'b0), IDLE(), 1'b1, 1'b0, 1'b0), 1'b0);
    mid_reset();
    apply(V(RD(32'd1, 1'b0), RD(32'd9, 1'b0), 1'b1, 1'b0, 1'b0), 1'b1);
    apply(V(IDLE(), RD(32'd9, 1'b0), 1'b0, 1'b1, 1'b0), 1'b1);

    // Reset clears a lock held by port 1.
    apply(V(IDLE(), RD(32'd3, 1'b1), 1'b0, 1'b1, 1'b0), 1'b0);
    mid_reset();
    apply(V(RD(32'd3, 1'b0), IDLE(), 1'b1, 1'b0, 1'b0), 1'b1);

    repeat (3) apply(V(IDLE(), IDLE(), 1'b0, 1'b0, 1'b0), 1'b1);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
